// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic DEPTH-stage pipeline register chain with per-stage
// stall/flush, valid tracking, occupancy count and output back-pressure.
// Payload is an opaque WIDTH-bit vector (typically a packed stage struct).
//
// Optional feature macro: PIPE_BUBBLE_COLLAPSE_EN
//   defined   : an invalid stage keeps accepting while downstream holds, so
//               bubbles are squeezed out (stall[i] still forces a hold).
//   undefined : rigid lock-step hold chain (classic in-order pipe).
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  input  logic [DEPTH-1:0]   stall,
  input  logic [DEPTH-1:0]   flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [DEPTH-1:0]   stage_vld,
  output logic [OCC_W-1:0]   occupancy
);

  // Stage state
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q;
  logic [OCC_W-1:0]             occ_q;

  // Next-state and hold chain
  logic [DEPTH:0]               hold;
  logic [DEPTH-1:0]             vld_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]  data_nxt;
  logic [OCC_W-1:0]             occ_nxt;

  // Upstream view of each stage: stage 0 sees the input port, stage i sees i-1
  logic [DEPTH-1:0]             up_vld;
  logic [DEPTH-1:0][WIDTH-1:0]  up_data;
  logic [DEPTH-1:0]             up_hold;

  // Hold chain, computed from the output back toward the input
  always_comb begin
    hold        = '0;
    hold[DEPTH] = ~out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef PIPE_BUBBLE_COLLAPSE_EN
      hold[i] = stall[i] | (vld_q[i] & hold[i+1]);
`else
      hold[i] = stall[i] | hold[i+1];
`endif
    end
  end

  // Upstream source selection per stage
  always_comb begin
    up_vld     = '0;
    up_data    = '0;
    up_hold    = '0;
    up_vld[0]  = in_valid;
    up_data[0] = in_data;
    up_hold[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_q[i-1];
      up_data[i] = data_q[i-1];
      up_hold[i] = hold[i-1];
    end
  end

  // Per-stage update: flush, then hold, then bubble, then advance
  always_comb begin
    vld_nxt  = vld_q;
    data_nxt = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) begin
        vld_nxt[i] = 1'b0;
      end else if (hold[i]) begin
        vld_nxt[i] = vld_q[i];
      end else if (up_hold[i]) begin
        vld_nxt[i] = 1'b0;
      end else begin
        vld_nxt[i]  = up_vld[i];
        data_nxt[i] = up_data[i];
      end
    end
  end

  // Population count of the next valid vector
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
    end
  end

  // State registers; reset clears data too so invalid stages never read X
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      data_q <= '0;
      occ_q  <= '0;
    end else begin
      vld_q  <= vld_nxt;
      data_q <= data_nxt;
      occ_q  <= occ_nxt;
    end
  end

  assign in_ready  = ~hold[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign stage_vld = vld_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=3, WIDTH=32).
module tb_pipe_stage_chain;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic [DEPTH-1:0]  stall;
  logic [DEPTH-1:0]  flush;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [DEPTH-1:0]  stage_vld;
  logic [1:0]        occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stage_vld (stage_vld),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    stall = '0; flush = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_vld", 32'(stage_vld), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_ovld", 32'(out_valid), 32'h0);
    chk("rst_odata", out_data, 32'h0);

    // 1: three back-to-back items, latency DEPTH-1 after acceptance
    in_valid = 1'b1; in_data = 32'h11; #1;
    chk("t1_inrdy", 32'(in_ready), 32'h1);
    step();
    chk("t1_vld_a", 32'(stage_vld), 32'h1);
    chk("t1_ovld_a", 32'(out_valid), 32'h0);
    in_data = 32'h22; step();
    in_data = 32'h33; step();
    chk("t1_out11", out_data, 32'h11);
    chk("t1_ovld_b", 32'(out_valid), 32'h1);
    chk("t1_occ3", 32'(occupancy), 32'h3);
    in_valid = 1'b0; step();
    chk("t1_out22", out_data, 32'h22);
    chk("t1_occ2", 32'(occupancy), 32'h2);
    step();
    chk("t1_out33", out_data, 32'h33);
    chk("t1_occ1", 32'(occupancy), 32'h1);
    step();
    chk("t1_empty", 32'(stage_vld), 32'h0);
    chk("t1_occ0", 32'(occupancy), 32'h0);

    // 2: full pipe AA,BB,CC then stall stage 1 for one cycle
    in_valid = 1'b1;
    in_data = 32'hAA; step();
    in_data = 32'hBB; step();
    in_data = 32'hCC; step();
    chk("t2_full", 32'(stage_vld), 32'h7);
    chk("t2_outAA", out_data, 32'hAA);
    in_data = 32'hDD; stall = 3'b010; #1;
    chk("t2_inrdy", 32'(in_ready), 32'h0);
    step();
    chk("t2_vld", 32'(stage_vld), 32'h3);
    chk("t2_ovld", 32'(out_valid), 32'h0);
    chk("t2_occ", 32'(occupancy), 32'h2);
    stall = '0; in_data = 32'hEE; step();
    chk("t2_outBB", out_data, 32'hBB);
    chk("t2_vld_b", 32'(stage_vld), 32'h7);
    chk("t2_occ3", 32'(occupancy), 32'h3);

    // 3: flush stages 0 and 1 of a full pipe (stage0..2 = EE,CC,BB)
    flush = 3'b011; in_data = 32'hFF; #1;
    chk("t3_inrdy", 32'(in_ready), 32'h1);
    step();
    chk("t3_vld", 32'(stage_vld), 32'h4);
    chk("t3_outCC", out_data, 32'hCC);
    chk("t3_occ", 32'(occupancy), 32'h1);
    flush = '0; in_valid = 1'b0; step();
    chk("t3_drain", 32'(stage_vld), 32'h0);

    // 4: back-pressure with a bubble in stage 1 (stage_vld = 101)
    in_valid = 1'b1; in_data = 32'h41; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 32'h42; step();
    chk("t4_pre", 32'(stage_vld), 32'h5);
    out_ready = 1'b0; in_data = 32'h43; #1;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    chk("t4_inrdy", 32'(in_ready), 32'h1);
    step();
    chk("t4_vld", 32'(stage_vld), 32'h7);
    chk("t4_occ", 32'(occupancy), 32'h3);
`else
    chk("t4_inrdy", 32'(in_ready), 32'h0);
    step();
    chk("t4_vld", 32'(stage_vld), 32'h5);
    chk("t4_occ", 32'(occupancy), 32'h2);
`endif
    chk("t4_out41", out_data, 32'h41);
    chk("t4_ovld", 32'(out_valid), 32'h1);
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step(); step();
    chk("t4_drain", 32'(stage_vld), 32'h0);

    // 5: synchronous reset mid-stream
    in_valid = 1'b1; in_data = 32'h51; step();
    in_data = 32'h52; step();
    chk("t5_pre", 32'(stage_vld), 32'h3);
    reset = 1'b1; in_data = 32'h53; step();
    chk("t5_vld", 32'(stage_vld), 32'h0);
    chk("t5_occ", 32'(occupancy), 32'h0);
    chk("t5_ovld", 32'(out_valid), 32'h0);
    chk("t5_odata", out_data, 32'h0);
    reset = 1'b0; in_valid = 1'b0; step();
    chk("t5_nocap", 32'(stage_vld), 32'h0);

    // 6: flush and stall on stage 1 together, full pipe (61,62,63)
    in_valid = 1'b1;
    in_data = 32'h61; step();
    in_data = 32'h62; step();
    in_data = 32'h63; step();
    chk("t6_full", 32'(stage_vld), 32'h7);
    flush = 3'b010; stall = 3'b010; in_data = 32'h64; #1;
    chk("t6_inrdy", 32'(in_ready), 32'h0);
    step();
    chk("t6_vld", 32'(stage_vld), 32'h1);
    chk("t6_occ", 32'(occupancy), 32'h1);
    flush = '0; stall = '0; in_valid = 1'b0; step();
    chk("t6_adv", 32'(stage_vld), 32'h2);
    step();
    chk("t6_out63", out_data, 32'h63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
